switch_allocator: RTL
=====================

# switch_allocator

Per-output packet-level switch allocator for the router crossbar. Each cycle it arbitrates among input ports whose head flit targets a given output. It uses round-robin, one arbiter per output. It then locks that output to the winning input until the packet's tail flit has transferred. Its registered outputs drive the crossbar's `routeSelect`, `outputBusy` and `PortReserved` controls inside one VC plane of the router pipeline.

## Interface
- `INPUTS`, 5, number of input ports
- `OUTPUTS`, 5, number of output ports
- `TYPE_WIDTH`, 2, flit type field width
- `REQUEST_WIDTH`, `$clog2(OUTPUTS)`, port index width; must be ≥ `$clog2(INPUTS)` and ≥ `$clog2(OUTPUTS)`
- `WATCHDOG_CYCLES`, 1024, stall limit per locked output (used only with `SA_WATCHDOG_EN`)
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `req_valid`  in  INPUTS  input i has a flit at its buffer front
- `req_dest`  in  INPUTS*REQUEST_WIDTH  output port requested by input i (slice i)
- `flit_type_in`  in  INPUTS*TYPE_WIDTH  type of front flit of input i: 01 head, 10 body, 11 tail, 00 none
- `valid_out_bus`  in  OUTPUTS  crossbar output valid
- `ready_out_bus`  in  OUTPUTS  downstream ready per output
- `routeSelect`  out  OUTPUTS*REQUEST_WIDTH  input index driving output o
- `outputBusy`  out  OUTPUTS  output o locked to an input
- `PortReserved`  out  INPUTS  input i holds a grant
- `watchdog_expired`  out  OUTPUTS  one-cycle pulse on forced release

## Operation
- Per-output FSM with two states:
  - IDLE → LOCKED when at least one candidate exists.
  - LOCKED → IDLE on a tail transfer, or on watchdog expiry.
- Candidate for output o: input i with `req_valid[i]`, `flit_type_in[i]==01`, `req_dest[i]==o`, and `PortReserved[i]==0`.
- Arbitration: round-robin pointer `ptr[o]`; the search starts at `ptr[o]` and wraps modulo INPUTS.
  - Winner w: `routeSelect[o]<=w`, `outputBusy[o]<=1`, `PortReserved[w]<=1`, `ptr[o]<=(w+1)%INPUTS` (INPUTS-1 wraps to 0).
- Transfer on output o: `valid_out_bus[o] & ready_out_bus[o]` while LOCKED.
- Tail transfer: a transfer with `flit_type_in[routeSelect[o]]==11`. It releases the lock: `outputBusy[o]<=0`, `PortReserved[routeSelect[o]]<=0`.
  - `routeSelect[o]` holds its last value while IDLE.
- Head, body and none flits never release a lock.
- A body or tail flit at an input with no grant is ignored.
- An input requests exactly one output per cycle, so it can win at most one output. Outputs arbitrate independently in the same cycle.
- Single-flit packets are sent as head followed by tail; there is no head+tail encoding.
- Invalid `req_dest` (≥ OUTPUTS) is never granted.

## Timing
- Reset values: all `outputBusy`, `PortReserved`, `routeSelect`, `watchdog_expired` and `ptr` are 0; all FSMs IDLE.
- `rst` asserted mid-packet clears all locks at the next edge. In-flight packets are abandoned; upstream flush is owned elsewhere.
- Grant latency: a candidate present at edge t gives a grant visible after edge t; the head flit may transfer from cycle t+1.
- Release: a tail transfer in cycle t puts the output IDLE in cycle t+1. The earliest re-grant is visible in t+2, giving one bubble cycle per packet boundary.
- The tail-release edge and a new arbitration never share a cycle for the same output.
- `PortReserved[w]` clear and a new grant of the same w by a different output: the earliest re-grant of w is visible the cycle after its release.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SA_WATCHDOG_EN` defined:
  - Each output has a stall counter of width `$clog2(WATCHDOG_CYCLES+1)`.
  - The counter clears on entering LOCKED and on every transfer, and increments on each LOCKED cycle without a transfer.
  - When it reaches WATCHDOG_CYCLES-1, the output is forced IDLE at the next edge, `PortReserved` of the holder is cleared, and `watchdog_expired[o]` pulses for exactly that cycle.
- `SA_WATCHDOG_EN` undefined: no counters; locks are held indefinitely; `watchdog_expired` is tied to 0.

## Structure
- Package `sa_pkg` holds:
  - flit type constants `FLIT_NONE`, `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`
  - the FSM state enum `{SA_IDLE, SA_LOCKED}`
- Sub-module `rr_arbiter`: INPUTS-wide request vector and pointer in, one-hot grant plus index out. It is combinational and instantiated once per output. The pointer and FSM registers stay in `switch_allocator`.

## Test plan
- Single packet:
  - Stimulus: input 2 head to output 4 at cycle 0; flits transfer cycles 1–3 with the tail at cycle 3.
  - Required: `routeSelect[4]=2` and `outputBusy[4]=1` from cycle 1; both busy and `PortReserved[2]` clear in cycle 4.
- Contention:
  - Stimulus: inputs 0, 1, 3 all send heads to output 0 continuously, each packet 2 flits.
  - Required: grant order 0, 1, 3, 0; one bubble cycle between packets.
- Back-pressure:
  - Stimulus: `ready_out_bus[1]=0` for 20 cycles mid-packet.
  - Required: the lock is held and `routeSelect[1]` is unchanged; release follows only the tail transfer.
- Parallel:
  - Stimulus: input 0→output 1 and input 1→output 0 in the same cycle.
  - Required: both granted in the same cycle; a body flit at unlocked input 4 causes no grant.
- Reset mid-packet:
  - Stimulus: `rst` high for 1 cycle while outputs 0 and 2 are locked.
  - Required: all outputs 0 the next cycle, then a fresh arbitration starting from pointer 0.
- With `SA_WATCHDOG_EN` and WATCHDOG_CYCLES=8:
  - Stimulus: a locked output sees no transfer for 8 cycles.
  - Required: `watchdog_expired` pulses for 1 cycle, the output goes IDLE, and a waiting head is granted 1 cycle later.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// sa_pkg: shared constants and types for the switch allocator.
//   FLIT_*      : front-flit type encodings seen on flit_type_in
//   sa_state_e  : per-output lock state
package sa_pkg;

  localparam logic [1:0] FLIT_NONE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_e;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   in  N    request vector
//   ptr   in  PW   index where the search starts (wraps modulo N)
//   grant out N    one-hot winner (all zero when no request)
//   idx   out PW   winner index
//   found out 1    at least one request present
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = PW'(c);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output packet-level allocator for the crossbar.
// Each output round-robins among inputs whose head flit targets it, then
// stays locked to the winner until that packet's tail flit transfers.
//
// Optional feature macro: SA_WATCHDOG_EN (stall watchdog that force-releases
// a locked output after WATCHDOG_CYCLES cycles without a transfer).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid         per input: flit present at buffer front
//   req_dest          per input: requested output (REQUEST_WIDTH slices)
//   flit_type_in      per input: front flit type (TYPE_WIDTH slices)
//   valid_out_bus     per output: crossbar output valid
//   ready_out_bus     per output: downstream ready
//   routeSelect       per output: input index driving it (registered)
//   outputBusy        per output: locked to an input (registered)
//   PortReserved      per input: holds a grant (registered)
//   watchdog_expired  per output: one-cycle pulse on forced release
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | output free; arbitrates among candidate heads every cycle
// LOCKED| output owned by routeSelect[o] until tail transfer / watchdog
module switch_allocator
  import sa_pkg::*;
#(
  parameter int INPUTS          = 5,
  parameter int OUTPUTS         = 5,
  parameter int TYPE_WIDTH      = 2,
  parameter int REQUEST_WIDTH   = $clog2(OUTPUTS),
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUTS-1:0]                  req_valid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0]    req_dest,
  input  logic [INPUTS*TYPE_WIDTH-1:0]       flit_type_in,
  input  logic [OUTPUTS-1:0]                 valid_out_bus,
  input  logic [OUTPUTS-1:0]                 ready_out_bus,
  output logic [OUTPUTS*REQUEST_WIDTH-1:0]   routeSelect,
  output logic [OUTPUTS-1:0]                 outputBusy,
  output logic [INPUTS-1:0]                  PortReserved,
  output logic [OUTPUTS-1:0]                 watchdog_expired
);

  localparam int PW = REQUEST_WIDTH;

  sa_state_e          state [OUTPUTS];
  logic [PW-1:0]      ptr   [OUTPUTS];
  logic [INPUTS-1:0]  cand  [OUTPUTS];
  logic [INPUTS-1:0]  gnt   [OUTPUTS];
  logic [PW-1:0]      gidx  [OUTPUTS];
  logic [OUTPUTS-1:0] found;
  logic [OUTPUTS-1:0] xfer;
  logic [OUTPUTS-1:0] tail_xfer;
  logic [OUTPUTS-1:0] release_now;
  logic [OUTPUTS-1:0] wd_hit;
  logic [INPUTS-1:0]  pr_next;

  // Candidate heads per output. A reserved input is already mid-packet on
  // some output, so its front flit cannot open a new packet elsewhere.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      for (int i = 0; i < INPUTS; i++) begin
        cand[o][i] = req_valid[i]
                   && (flit_type_in[i*TYPE_WIDTH +: TYPE_WIDTH] == TYPE_WIDTH'(FLIT_HEAD))
                   && (req_dest[i*PW +: PW] == PW'(o))
                   && !PortReserved[i];
      end
    end
  end

  // Transfer detection uses the flit type of the current holder.
  always_comb begin
    logic [PW-1:0]         sel;
    logic [TYPE_WIDTH-1:0] ht;
    sel       = '0;
    ht        = '0;
    xfer      = '0;
    tail_xfer = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      sel = routeSelect[o*PW +: PW];
      if (int'(sel) < INPUTS) ht = flit_type_in[int'(sel)*TYPE_WIDTH +: TYPE_WIDTH];
      else                    ht = TYPE_WIDTH'(FLIT_NONE);
      xfer[o]      = (state[o] == SA_LOCKED) && valid_out_bus[o] && ready_out_bus[o];
      tail_xfer[o] = xfer[o] && (ht == TYPE_WIDTH'(FLIT_TAIL));
    end
  end

  assign release_now = tail_xfer | wd_hit;

  // Reservation update: grants set, releases clear. A set and a clear of the
  // same input never coincide because a grant needs the bit already clear.
  always_comb begin
    logic [PW-1:0] sel;
    sel     = '0;
    pr_next = PortReserved;
    for (int o = 0; o < OUTPUTS; o++) begin
      sel = routeSelect[o*PW +: PW];
      if (state[o] == SA_IDLE) begin
        pr_next = pr_next | gnt[o];
      end else if (release_now[o] && (int'(sel) < INPUTS)) begin
        pr_next[int'(sel)] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_arb
    rr_arbiter #(
      .N  (INPUTS),
      .PW (PW)
    ) u_arb (
      .req   (cand[g]),
      .ptr   (ptr[g]),
      .grant (gnt[g]),
      .idx   (gidx[g]),
      .found (found[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state[o] <= SA_IDLE;
        ptr[o]   <= '0;
      end
      routeSelect  <= '0;
      outputBusy   <= '0;
      PortReserved <= '0;
    end else begin
      PortReserved <= pr_next;
      for (int o = 0; o < OUTPUTS; o++) begin
        case (state[o])
          SA_IDLE: begin
            if (found[o]) begin
              state[o]                 <= SA_LOCKED;
              routeSelect[o*PW +: PW]  <= gidx[o];
              outputBusy[o]            <= 1'b1;
              ptr[o]                   <= (int'(gidx[o]) == INPUTS-1) ? '0 : gidx[o] + 1'b1;
            end
          end
          SA_LOCKED: begin
            // routeSelect keeps its last value after release.
            if (release_now[o]) begin
              state[o]      <= SA_IDLE;
              outputBusy[o] <= 1'b0;
            end
          end
          default: begin
            state[o]      <= SA_IDLE;
            outputBusy[o] <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SA_WATCHDOG_EN
  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

  logic [CW-1:0] stall [OUTPUTS];

  // Counter sits at zero while IDLE, so it is already clear on lock entry.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      wd_hit[o] = (state[o] == SA_LOCKED) && !xfer[o]
                && (stall[o] == CW'(WATCHDOG_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OUTPUTS; o++) stall[o] <= '0;
      watchdog_expired <= '0;
    end else begin
      watchdog_expired <= wd_hit;
      for (int o = 0; o < OUTPUTS; o++) begin
        if ((state[o] != SA_LOCKED) || xfer[o] || wd_hit[o]) stall[o] <= '0;
        else                                                 stall[o] <= stall[o] + 1'b1;
      end
    end
  end
`else
  assign wd_hit           = '0;
  assign watchdog_expired = '0;
`endif

endmodule
